// File: rtl/scrambler_am_scheduler.sv
// Transmit slot scheduler: splits each AM period into a marker window and a data
// window, steering the scrambler, encoder handshake and AM inserter per slot.
module scrambler_am_scheduler #(
  parameter int AM_PERIOD  = 16384,
  parameter int N_AM_SLOTS = 20,
  parameter int NB_CNT     = 14,
  parameter int NB_AM_IDX  = 5
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic                 i_slot,
  input  logic                 i_cfg_bypass,
  input  logic                 i_cfg_am_en,
  output logic                 o_scr_enable,
  output logic                 o_scr_bypass,
  output logic                 o_ready,
  output logic                 o_am_insert,
  output logic [NB_AM_IDX-1:0] o_am_index,
  output logic                 o_period_start
);

  typedef enum logic [1:0] {IDLE, AM_WIN, DATA} state_t;

  localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(AM_PERIOD - 1);
  localparam logic [NB_CNT-1:0] AM_LAST  = NB_CNT'(N_AM_SLOTS - 1);
  localparam logic [NB_CNT-1:0] CNT_ONE  = NB_CNT'(1);

  state_t              state_q, state_d;
  logic [NB_CNT-1:0]   cnt_q, cnt_d;
  logic                bypass_lat_q, bypass_lat_d;
  logic                am_en_lat_q, am_en_lat_d;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bypass_lat_q <= 1'b0;
      am_en_lat_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bypass_lat_q <= bypass_lat_d;
      am_en_lat_q  <= am_en_lat_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bypass_lat_d = bypass_lat_q;
    am_en_lat_d  = am_en_lat_q;
    case (state_q)
      IDLE: begin
        if (i_enable) begin
          bypass_lat_d = i_cfg_bypass;
          am_en_lat_d  = i_cfg_am_en;
          cnt_d        = '0;
          state_d      = i_cfg_am_en ? AM_WIN : DATA;
        end
      end
      AM_WIN: begin
        if (!i_enable) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (i_slot) begin
          if (cnt_q == AM_LAST) state_d = DATA;
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DATA: begin
        if (!i_enable) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (i_slot) begin
          // Period wrap is the only point where software config takes effect
          if (cnt_q == CNT_LAST) begin
            cnt_d        = '0;
            bypass_lat_d = i_cfg_bypass;
            am_en_lat_d  = i_cfg_am_en;
            state_d      = i_cfg_am_en ? AM_WIN : DATA;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are forced low while reset is asserted, regardless of register contents
  always_comb begin
    o_scr_enable   = 1'b0;
    o_scr_bypass   = 1'b0;
    o_ready        = 1'b0;
    o_am_insert    = 1'b0;
    o_am_index     = '0;
    o_period_start = 1'b0;
    if (!i_reset) begin
      o_scr_enable   = i_slot && (state_q != IDLE);
      o_scr_bypass   = (state_q == AM_WIN) || (bypass_lat_q && (state_q == DATA));
      o_ready        = i_slot && (state_q == DATA);
      o_am_insert    = i_slot && (state_q == AM_WIN);
      o_am_index     = (state_q == AM_WIN) ? cnt_q[NB_AM_IDX-1:0] : '0;
      o_period_start = i_slot && (cnt_q == '0) && (state_q != IDLE);
    end
  end

endmodule
